adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine: RTL and testbench



---
 rtl/adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv | 147 ++++++++++++++
 tb/tb_adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv
// rtl/adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv - debug-RAM single-word access engine
//
// Purpose: executes the JTAG debug-slave wrapper's ocimem commands as
// single-word reads/writes on the on-chip debug RAM, yielding to the CPU
// while it owns the RAM and aborting if it is held off for too long.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   take_action_ocimem_a       pulse: load address from jdo, optional read
//   take_action_ocimem_b       pulse: write jdo data at current address
//   take_no_action_ocimem_a    pulse: read current address
//   jdo[37:0]                  JTAG data word, valid with the pulse
//   cpu_busy                   CPU owns the debug RAM this cycle
//   ram_rdata[31:0]            RAM read data, one cycle after ram_re
//   ram_addr, ram_wdata        registered address pointer / write data
//   ram_we, ram_re             single-cycle RAM strobes
//   MonDReg[31:0]              last read data
//   monitor_ready              engine idle, result valid
//   monitor_error              sticky error (overrun or timeout)

module adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic              cpu_busy,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // The counter is cleared on entry to ISSUE and counts busy cycles already
  // spent, so the TIMEOUT-th consecutive busy cycle is the one that sees
  // TIMEOUT-1 and aborts.
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        op_write;
  logic [15:0] stall_cnt;

  logic              in_idle;
  logic              any_pulse;
  logic              issue_go;
  logic              timeout_hit;
  logic              overrun;
  logic              err_clear;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] addr_inc;

  // jdo bits not carried by any command field.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign in_idle     = (state == ST_IDLE);
  assign any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign issue_go    = (state == ST_ISSUE) & ~cpu_busy;
  assign timeout_hit = (state == ST_ISSUE) & cpu_busy & (stall_cnt == STALL_LIMIT);
  assign overrun     = ~in_idle & any_pulse;
  assign err_clear   = in_idle & take_action_ocimem_a & jdo[34];
  assign jdo_addr    = jdo[ADDR_W+16:17];
  assign addr_inc    = ram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Strobes are combinational so the RAM sees them in the same cycle the
  // CPU releases it; a busy cycle can never produce a strobe.
  assign ram_we        = issue_go & op_write;
  assign ram_re        = issue_go & ~op_write;
  assign monitor_ready = in_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      op_write      <= 1'b0;
      stall_cnt     <= 16'd0;
      ram_addr      <= '0;
      ram_wdata     <= 32'd0;
      MonDReg       <= 32'd0;
      monitor_error <= 1'b0;
    end else begin
      // A new error in the same cycle as a clear leaves the flag set.
      monitor_error <= (monitor_error & ~err_clear) | overrun | timeout_hit;

      case (state)
        ST_IDLE: begin
          // action_a > action_b > no_action_a; losers are silently dropped.
          if (take_action_ocimem_a) begin
            ram_addr <= jdo_addr;
            if (jdo[35]) begin
              op_write  <= 1'b0;
              stall_cnt <= 16'd0;
              state     <= ST_ISSUE;
            end
          end else if (take_action_ocimem_b) begin
            ram_wdata <= jdo[34:3];
            op_write  <= 1'b1;
            stall_cnt <= 16'd0;
            state     <= ST_ISSUE;
          end else if (take_no_action_ocimem_a) begin
            op_write  <= 1'b0;
            stall_cnt <= 16'd0;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (cpu_busy) begin
            // Abort leaves address and MonDReg untouched.
            if (stall_cnt == STALL_LIMIT) begin
              state <= ST_IDLE;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else if (op_write) begin
            ram_addr <= addr_inc;
            state    <= ST_IDLE;
          end else begin
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          MonDReg  <= ram_rdata;
          ram_addr <= addr_inc;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv
// tb/tb_adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine.sv - self-checking bench for the debug-RAM engine

module tb_adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic        cpu_busy;
  logic [31:0] ram_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  adaptor2x2_nios2_gen2_11_cpu_debug_mem_engine #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .cpu_busy                (cpu_busy),
    .ram_rdata               (ram_rdata),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back as A5A5_00xx with xx = address.
  logic [31:0]  mem [0:255];
  logic [255:0] written = '0;
  int           strobes = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    if (ram_re) ram_rdata <= written[ram_addr] ? mem[ram_addr] : {24'hA5A500, ram_addr};
    if (ram_we || ram_re) strobes <= strobes + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 (just after an edge); returns in cycle 1.
  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    jdo                     = j;
    step();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!monitor_ready && n < budget) begin
      step();
      n++;
    end
    chk({name, "_ready"}, {31'd0, monitor_ready}, 32'd1);
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic clr, input logic [7:0] a);
    logic [37:0] v = '0;
    v[35]    = rd;
    v[34]    = clr;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] v = '0;
    v[34:3] = d;
    return v;
  endfunction

  // kind: 0 = action_a, 1 = action_b, 2 = no_action_a
  typedef struct {
    int          kind;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_mon;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs[10];
  int   s0;

  initial begin
    vecs[0] = '{0, 1'b0, 8'h10, 32'h0,        32'h00000000, 8'h10};
    vecs[1] = '{1, 1'b0, 8'h00, 32'hDEADBEEF, 32'h00000000, 8'h11};
    vecs[2] = '{0, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 8'h11};
    vecs[3] = '{0, 1'b0, 8'h20, 32'h0,        32'hDEADBEEF, 8'h20};
    vecs[4] = '{1, 1'b0, 8'h00, 32'h12345678, 32'hDEADBEEF, 8'h21};
    vecs[5] = '{0, 1'b1, 8'h20, 32'h0,        32'h12345678, 8'h21};
    vecs[6] = '{2, 1'b0, 8'h00, 32'h0,        32'hA5A50021, 8'h22};
    vecs[7] = '{0, 1'b0, 8'hFF, 32'h0,        32'hA5A50021, 8'hFF};
    vecs[8] = '{2, 1'b0, 8'h00, 32'h0,        32'hA5A500FF, 8'h00};
    vecs[9] = '{2, 1'b0, 8'h00, 32'h0,        32'hA5A50000, 8'h01};

    reset = 1'b1;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo      = '0;
    cpu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mon",   MonDReg, 32'd0);
    chk("rst_ready", {31'd0, monitor_ready}, 32'd1);
    chk("rst_err",   {31'd0, monitor_error}, 32'd0);
    chk("rst_addr",  {24'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_strb",  {30'd0, ram_we, ram_re}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      case (vecs[i].kind)
        0:       pulse(1'b1, 1'b0, 1'b0, mk_a(vecs[i].rd, 1'b0, vecs[i].addr));
        1:       pulse(1'b0, 1'b1, 1'b0, mk_b(vecs[i].data));
        default: pulse(1'b0, 1'b0, 1'b1, '0);
      endcase
      wait_ready(20, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mon", i),  MonDReg, vecs[i].exp_mon);
      chk($sformatf("vec%0d_addr", i), {24'd0, ram_addr}, {24'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_err", i),  {31'd0, monitor_error}, 32'd0);
    end

    // Write cycle timing.
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 8'h30));
    pulse(1'b0, 1'b1, 1'b0, mk_b(32'hCAFEF00D));
    chk("wr_c1_we",    {30'd0, ram_we, ram_re}, 32'd2);
    chk("wr_c1_addr",  {24'd0, ram_addr}, 32'h30);
    chk("wr_c1_wdata", ram_wdata, 32'hCAFEF00D);
    chk("wr_c1_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("wr_c2_ready", {31'd0, monitor_ready}, 32'd1);
    chk("wr_c2_addr",  {24'd0, ram_addr}, 32'h31);
    chk("wr_c2_we",    {31'd0, ram_we}, 32'd0);

    // Read cycle timing.
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h30));
    chk("rd_c1_re",    {30'd0, ram_we, ram_re}, 32'd1);
    chk("rd_c1_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("rd_c2_re",    {31'd0, ram_re}, 32'd0);
    chk("rd_c2_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("rd_c3_ready", {31'd0, monitor_ready}, 32'd1);
    chk("rd_c3_mon",   MonDReg, 32'hCAFEF00D);
    chk("rd_c3_addr",  {24'd0, ram_addr}, 32'h31);

    // Five busy cycles delay the read strobe from cycle 1 to cycle 6.
    cpu_busy = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    chk("stall_c1_re", {31'd0, ram_re}, 32'd0);
    repeat (4) step();
    chk("stall_c5_re", {31'd0, ram_re}, 32'd0);
    step();
    cpu_busy = 1'b0;
    #1;
    chk("stall_c6_re", {31'd0, ram_re}, 32'd1);
    step();
    chk("stall_c7_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("stall_c8_ready", {31'd0, monitor_ready}, 32'd1);
    chk("stall_mon",  MonDReg, 32'hA5A50031);
    chk("stall_addr", {24'd0, ram_addr}, 32'h32);

    // Timeout after 255 busy cycles.
    s0 = strobes;
    cpu_busy = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, '0);
    repeat (254) step();
    chk("to_c255_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("to_ready",   {31'd0, monitor_ready}, 32'd1);
    chk("to_err",     {31'd0, monitor_error}, 32'd1);
    chk("to_addr",    {24'd0, ram_addr}, 32'h32);
    chk("to_mon",     MonDReg, 32'hA5A50031);
    chk("to_strobes", strobes - s0, 32'd0);
    cpu_busy = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h40));
    chk("clr_err",  {31'd0, monitor_error}, 32'd0);
    chk("clr_addr", {24'd0, ram_addr}, 32'h40);

    // Overrun during ISSUE: flagged, original read still completes once.
    pulse(1'b0, 1'b0, 1'b1, '0);
    s0 = strobes;
    pulse(1'b0, 1'b0, 1'b1, '0);
    chk("ovr_err",   {31'd0, monitor_error}, 32'd1);
    chk("ovr_ready", {31'd0, monitor_ready}, 32'd0);
    step();
    chk("ovr_mon",   MonDReg, 32'hA5A50040);
    chk("ovr_addr",  {24'd0, ram_addr}, 32'h41);
    step();
    chk("ovr_ready2",  {31'd0, monitor_ready}, 32'd1);
    chk("ovr_strobes", strobes - s0, 32'd1);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h50));
    chk("ovr_clr", {31'd0, monitor_error}, 32'd0);

    // action_a and action_b together: only the address loads.
    s0 = strobes;
    pulse(1'b1, 1'b1, 1'b0, mk_a(1'b0, 1'b0, 8'h60));
    repeat (3) step();
    chk("pri_strobes", strobes - s0, 32'd0);
    chk("pri_addr",    {24'd0, ram_addr}, 32'h60);
    chk("pri_ready",   {31'd0, monitor_ready}, 32'd1);
    chk("pri_err",     {31'd0, monitor_error}, 32'd0);

    // Reset during CAPTURE (with the error flag set by an overrun).
    pulse(1'b0, 1'b0, 1'b1, '0);
    pulse(1'b0, 1'b0, 1'b1, '0);
    chk("mid_ready_pre", {31'd0, monitor_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_ready", {31'd0, monitor_ready}, 32'd1);
    chk("mid_mon",   MonDReg, 32'd0);
    chk("mid_err",   {31'd0, monitor_error}, 32'd0);
    chk("mid_addr",  {24'd0, ram_addr}, 32'd0);
    s0 = strobes;
    step();
    reset = 1'b0;
    repeat (2) step();
    chk("mid_strobes", strobes - s0, 32'd0);
    chk("mid_ready2",  {31'd0, monitor_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
